keccak_round_sequencer: RTL
===========================

Name: keccak_round_sequencer

Overview:
Sequential round controller for the Keccak-f permutation core. It runs the round counter and a start/done handshake with the core's datapath. It generates each round constant on the fly with the FIPS 202 rc(t) LFSR, so no constant table is needed. It sits between the absorb/squeeze control and the permutation datapath, driving round enable, round number and the ι-step constant.

Parameters:
W, 8, lane width; 8 selects Keccak-f[200] (18 rounds), 64 selects Keccak-f[1600] (24 rounds); other values are illegal and must trigger an elaboration error.
CYCLES_PER_ROUND, 1, clock cycles per round, for pipelined/DOM datapaths; range 1..15.
ROUNDS, localparam, 18 if W==8, else 24.

Ports:
ClkxCI  in  1  clock, rising edge
RstxRBI  in  1  asynchronous active-low reset
StartxSI  in  1  start request; sampled only in IDLE, or in DONE together with AckxSI
AbortxSI  in  1  synchronous abort; return to IDLE
AckxSI  in  1  consumer acknowledge of DonexSO
ReadyxSO  out  1  high in IDLE
RoundEnxSO  out  1  state-register update strobe, last cycle of each round
FirstRoundxSO  out  1  high throughout round 0 while in RUN
LastRoundxSO  out  1  high throughout round ROUNDS-1 while in RUN
RoundNrxDO  out  5  current round index
RCxDO  out  W  round constant for RoundNrxDO; zero outside RUN
DonexSO  out  1  permutation complete; held until acknowledged

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free. All state is in registers; all outputs are combinational decodes of those registers only. There is no input-to-output combinational path.
- Reset (async, RstxRBI=0) puts the block in:
  - state IDLE, RoundNr 0, cycle counter 0, LFSR 8'h01.
  - ReadyxSO=1; DonexSO, RoundEnxSO, First/LastRoundxSO = 0; RCxDO=0.
- IDLE:
  - StartxSI=1 at edge k moves to RUN, with RoundNr=0, cycle counter=0, LFSR=8'h01.
  - Round 0 is therefore visible from cycle k+1.
- RUN:
  - The cycle counter increments each cycle.
  - RoundEnxSO=1 when counter==CYCLES_PER_ROUND-1.
  - On that edge the counter clears, RoundNr increments and the LFSR advances 7 steps.
  - If RoundNr==ROUNDS-1 on that edge, go to DONE instead. RoundNr then holds ROUNDS-1 and the LFSR is not advanced.
- LFSR:
  - 8-bit Galois register for x^8+x^6+x^5+x^4+1; rc(t) is its bit 0 after t steps.
  - Per round, compute 7 bits rc(7·ir+j), j=0..6, combinationally by an unrolled 7-step chain from the current state.
  - RC bit position 2^j−1 = rc(7·ir+j) for j where 2^j−1 < W: j=0..3 for W=8, j=0..6 for W=64. All other bits are 0.
  - The next-LFSR value is the 7th step of the same chain.
- DONE:
  - DonexSO=1 and is held.
  - AckxSI=1 alone moves to IDLE.
  - AckxSI=1 with StartxSI=1 moves directly to RUN, round 0, LFSR reloaded (back-to-back permutations).
- Ignored inputs: StartxSI in RUN; AckxSI outside DONE.
- AbortxSI has the highest priority. In RUN or DONE it moves to IDLE next edge, with counters and LFSR reset as at reset. Abort with Start in IDLE stays in IDLE.
- CYCLES_PER_ROUND=1: RoundEnxSO is high every RUN cycle. Total RUN duration is ROUNDS·CYCLES_PER_ROUND cycles.
- Round counter never exceeds ROUNDS-1; no wrap-around in RUN.

Decomposition:
- Shared package keccak_pkg holds:
  - ROUNDS_200=18, ROUNDS_1600=24
  - RC_LFSR_POLY=8'h71 (Galois taps)
  - RC_LFSR_INIT=8'h01
  - the state enum {IDLE, RUN, DONE}
  - function rc_bits(lfsr) returning the 7 rc bits plus the next state.
- One natural sub-module: keccak_rc_lfsr, holding the LFSR register, 7-step unroll, load/advance controls and W-wide RC expansion. The FSM and counters stay in the top.

Test Plan:
- W=64, CPR=1, Start pulse at edge k:
  - round 0 at k+1 with RC=64'h1; round 1 RC=64'h8082; round 2 RC=64'h800000000000808A; round 23 RC=64'h8000000080008008.
  - DonexSO rises at k+25 and 24 RoundEn pulses occur.
- W=8, CPR=1: the RC sequence over rounds 0..17 is 01,82,8A,00,8B,01,81,09,8A,88,09,0A,8B,8B,89,03,02,80; DonexSO follows after 18 rounds.
- W=8, CPR=4:
  - RoundEnxSO high on every 4th RUN cycle; RoundNr changes only after each strobe.
  - DONE is entered 72 cycles after RUN entry.
  - FirstRoundxSO covers the first 4 cycles; LastRoundxSO covers the last 4.
- Handshake:
  - DonexSO holds for 10 cycles without AckxSI.
  - Ack+Start in the same cycle restarts with RC=01 next cycle, with no IDLE cycle in between.
  - Start pulsed during RUN has no effect.
- AbortxSI in round 5: IDLE and ReadyxSO=1 next cycle, RCxDO=0. The next Start produces round 0 RC=01 (LFSR reinitialised).
- RstxRBI asserted asynchronously mid-round 10: outputs take reset values immediately, without a clock edge. After release, the block idles until Start.

Source files
------------

// File: rtl/keccak_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_pkg : shared Keccak round-control constants, FSM states, rc(t) step
// Revision   : 1.0
// ---------------------------------------------------------------------------
package keccak_pkg;

  localparam int         ROUNDS_200   = 18;
  localparam int         ROUNDS_1600  = 24;
  localparam logic [7:0] RC_LFSR_POLY = 8'h71;
  localparam logic [7:0] RC_LFSR_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0] rc;
    logic [7:0] next;
  } rc_step_t;

  // Seven rc(t) output bits of one round plus the LFSR state for the next round
  function automatic rc_step_t rc_bits(input logic [7:0] lfsr);
    rc_step_t   res;
    logic [7:0] s;
    res = '0;
    s   = lfsr;
    for (int j = 0; j < 7; j++) begin
      res.rc[j] = s[0];
      s = {s[6:0], 1'b0} ^ (s[7] ? RC_LFSR_POLY : 8'h00);
    end
    res.next = s;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_round_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_round_sequencer_if : start/done handshake and round-control outputs
// Revision                  : 1.0
// ---------------------------------------------------------------------------
interface keccak_round_sequencer_if #(
  parameter int W = 8
);

  logic         StartxSI;
  logic         AbortxSI;
  logic         AckxSI;
  logic         ReadyxSO;
  logic         RoundEnxSO;
  logic         FirstRoundxSO;
  logic         LastRoundxSO;
  logic [4:0]   RoundNrxDO;
  logic [W-1:0] RCxDO;
  logic         DonexSO;

  modport master (
    output StartxSI, AbortxSI, AckxSI,
    input  ReadyxSO, RoundEnxSO, FirstRoundxSO, LastRoundxSO,
    input  RoundNrxDO, RCxDO, DonexSO
  );

  modport slave (
    input  StartxSI, AbortxSI, AckxSI,
    output ReadyxSO, RoundEnxSO, FirstRoundxSO, LastRoundxSO,
    output RoundNrxDO, RCxDO, DonexSO
  );

endinterface
`default_nettype wire

// File: rtl/keccak_rc_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_rc_lfsr : rc(t) LFSR with 7-step unroll and W-wide iota constant
// Revision       : 1.0
// ---------------------------------------------------------------------------
module keccak_rc_lfsr
  import keccak_pkg::*;
#(
  parameter int W = 8
) (
  input  wire          clk,
  input  wire          rst_n,
  input  wire          load,
  input  wire          advance,
  input  wire          enable,
  output logic [W-1:0] rc
);

  logic [7:0]   lfsr;
  rc_step_t     step;
  logic [W-1:0] rc_raw;
  logic         unused_rc;

  assign step = rc_bits(lfsr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= RC_LFSR_INIT;
    end else if (load) begin
      lfsr <= RC_LFSR_INIT;
    end else if (advance) begin
      lfsr <= step.next;
    end
  end

  // Only positions 2^j-1 carry a round-constant bit; for W=8 that is j=0..3
  for (genvar i = 0; i < W; i++) begin : g_rc
    if (((i + 1) & i) == 0) begin : g_tap
      assign rc_raw[i] = step.rc[$clog2(i + 1)];
    end else begin : g_zero
      assign rc_raw[i] = 1'b0;
    end
  end

  assign unused_rc = ^step.rc;
  assign rc        = enable ? rc_raw : '0;

endmodule
`default_nettype wire

// File: rtl/keccak_round_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_round_sequencer : Keccak-f round FSM, round/cycle counters, iota RC
// Revision               : 1.0
// ---------------------------------------------------------------------------
module keccak_round_sequencer
  import keccak_pkg::*;
#(
  parameter int W                = 8,
  parameter int CYCLES_PER_ROUND = 1
) (
  input  wire                     ClkxCI,
  input  wire                     RstxRBI,
  keccak_round_sequencer_if.slave bus
);

  localparam int         ROUNDS     = (W == 8) ? ROUNDS_200 : ROUNDS_1600;
  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
  localparam logic [3:0] LAST_CYCLE = 4'(CYCLES_PER_ROUND - 1);

  if (W != 8 && W != 64) begin : g_bad_width
    $error("keccak_round_sequencer: W must be 8 or 64");
  end

  if (CYCLES_PER_ROUND < 1 || CYCLES_PER_ROUND > 15) begin : g_bad_cpr
    $error("keccak_round_sequencer: CYCLES_PER_ROUND must be 1..15");
  end

  state_t     state;
  logic [4:0] round_nr;
  logic [3:0] cycle_cnt;
  logic       round_end;
  logic       last_round;
  logic       lfsr_load;
  logic       lfsr_advance;
  logic [W-1:0] rc;

  assign round_end  = (state == RUN) && (cycle_cnt == LAST_CYCLE);
  assign last_round = (round_nr == LAST_ROUND);

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      state     <= IDLE;
      round_nr  <= '0;
      cycle_cnt <= '0;
    end else if (bus.AbortxSI) begin
      state     <= IDLE;
      round_nr  <= '0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.StartxSI) begin
            state     <= RUN;
            round_nr  <= '0;
            cycle_cnt <= '0;
          end
        end
        RUN: begin
          if (cycle_cnt == LAST_CYCLE) begin
            cycle_cnt <= '0;
            // Round index saturates at the final round while DONE is shown
            if (last_round) begin
              state <= DONE;
            end else begin
              round_nr <= round_nr + 5'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 4'd1;
          end
        end
        DONE: begin
          if (bus.AckxSI) begin
            state     <= bus.StartxSI ? RUN : IDLE;
            round_nr  <= '0;
            cycle_cnt <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          round_nr  <= '0;
          cycle_cnt <= '0;
        end
      endcase
    end
  end

  // Holding the LFSR at its seed outside RUN makes every RUN entry start at rc(0)
  assign lfsr_load    = bus.AbortxSI || (state != RUN);
  assign lfsr_advance = round_end && !last_round;

  keccak_rc_lfsr #(
    .W (W)
  ) u_rc_lfsr (
    .clk     (ClkxCI),
    .rst_n   (RstxRBI),
    .load    (lfsr_load),
    .advance (lfsr_advance),
    .enable  (state == RUN),
    .rc      (rc)
  );

  assign bus.ReadyxSO      = (state == IDLE);
  assign bus.DonexSO       = (state == DONE);
  assign bus.RoundEnxSO    = round_end;
  assign bus.FirstRoundxSO = (state == RUN) && (round_nr == 5'd0);
  assign bus.LastRoundxSO  = (state == RUN) && last_round;
  assign bus.RoundNrxDO    = round_nr;
  assign bus.RCxDO         = rc;

endmodule
`default_nettype wire
